// File: rtl/ram_dp_fifo_buf_if.sv
// Handshake and status bundle for the router input-port FIFO buffer.
// master = link-side producer/consumer, slave = the buffer itself.
interface ram_dp_fifo_buf_if #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 3
);
   logic                  wr_valid;
   logic                  wr_ready;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  flush;
   logic [ADDR_WIDTH:0]   count;
   logic                  almost_full;
   logic                  wr_err;
   logic                  rd_err;

   modport master (
      output wr_valid, wr_data, rd_ready, flush,
      input  wr_ready, rd_valid, rd_data, count, almost_full, wr_err, rd_err
   );

   modport slave (
      input  wr_valid, wr_data, rd_ready, flush,
      output wr_ready, rd_valid, rd_data, count, almost_full, wr_err, rd_err
   );
endinterface

// File: rtl/ram_dp_fifo_buf.sv
// Dual-port RAM FIFO: write-only port 0, first-word fall-through read port 1,
// with occupancy count, registered almost-full, synchronous flush and sticky errors.
module ram_dp_fifo_buf #(
   parameter int DATA_WIDTH  = 12,
   parameter int ADDR_WIDTH  = 3,
   parameter int RAM_DEPTH   = 8,
   parameter int AFULL_LEVEL = 6
) (
   input logic               clk,
   input logic               rst,
   ram_dp_fifo_buf_if.slave  bus
);
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  afull_q, afull_d;
   logic                  wr_err_q, wr_err_d;
   logic                  rd_err_q, rd_err_d;

   logic wr_ready_w, rd_valid_w;
   logic wr_acc, rd_acc, mem_we;

   // Status depends on registered count only, so full/empty rules fall out directly.
   assign wr_ready_w = (count_q != DEPTH_C);
   assign rd_valid_w = (count_q != '0);

   always_comb begin
      wr_acc   = bus.wr_valid && wr_ready_w;
      rd_acc   = bus.rd_ready && rd_valid_w;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      wr_err_d = wr_err_q | (bus.wr_valid && !wr_ready_w);
      rd_err_d = rd_err_q | (bus.rd_ready && !rd_valid_w);
      mem_we   = 1'b0;

      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         mem_we = wr_acc;
         if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
         endcase
      end

      afull_d = (count_d >= AFULL_C);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         afull_q  <= 1'b0;
         wr_err_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         afull_q  <= afull_d;
         wr_err_q <= wr_err_d;
         rd_err_q <= rd_err_d;
      end
   end

   // Storage is deliberately not reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= bus.wr_data;
   end

   assign bus.wr_ready    = wr_ready_w;
   assign bus.rd_valid    = rd_valid_w;
   assign bus.rd_data     = rd_valid_w ? mem_q[rd_ptr_q] : '0;
   assign bus.count       = count_q;
   assign bus.almost_full = afull_q;
   assign bus.wr_err      = wr_err_q;
   assign bus.rd_err      = rd_err_q;
endmodule

// File: tb/tb_ram_dp_fifo_buf.sv
// Directed bench for ram_dp_fifo_buf with a queue scoreboard and a small occupancy model.
module tb_ram_dp_fifo_buf;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ram_dp_fifo_buf_if #(.DATA_WIDTH(12), .ADDR_WIDTH(3)) bus ();

   ram_dp_fifo_buf #(
      .DATA_WIDTH(12), .ADDR_WIDTH(3), .RAM_DEPTH(8), .AFULL_LEVEL(6)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int unsigned checks   = 0;
   int unsigned failures = 0;

   logic [11:0] sb_q [$];
   int unsigned m_count;
   logic        m_wr_err, m_rd_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_post(input string tag);
      chk({tag, "_count"}, 32'(bus.count), 32'(m_count));
      chk({tag, "_afull"}, 32'(bus.almost_full), 32'(m_count >= 6));
      chk({tag, "_wr_err"}, 32'(bus.wr_err), 32'(m_wr_err));
      chk({tag, "_rd_err"}, 32'(bus.rd_err), 32'(m_rd_err));
   endtask

   // One clock: drive inputs, check fall-through outputs, clock, update model, check state.
   task automatic cyc(input logic wv, input logic [11:0] wd, input logic rr,
                      input logic fl, input string tag);
      logic wr_acc, rd_acc;
      bus.wr_valid = wv;
      bus.wr_data  = wd;
      bus.rd_ready = rr;
      bus.flush    = fl;
      chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'(m_count != 0));
      chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'(m_count != 8));
      if (m_count != 0) chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'(sb_q[0]));
      else              chk({tag, "_rd_data0"}, 32'(bus.rd_data), 32'h0);
      wr_acc = wv && (m_count != 8);
      rd_acc = rr && (m_count != 0);
      if (wv && m_count == 8) m_wr_err = 1'b1;
      if (rr && m_count == 0) m_rd_err = 1'b1;
      @(posedge clk);
      #1;
      if (fl) begin
         sb_q.delete();
         m_count = 0;
      end else begin
         if (rd_acc) void'(sb_q.pop_front());
         if (wr_acc) sb_q.push_back(wd);
         m_count = sb_q.size();
      end
      chk_post(tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 12'hEEE;
      bus.rd_ready = 1'b1;
      bus.flush    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sb_q.delete();
      m_count  = 0;
      m_wr_err = 1'b0;
      m_rd_err = 1'b0;
      chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'h0);
      chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'h0);
      chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'h1);
      chk_post(tag);
      bus.wr_valid = 1'b0;
      bus.rd_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      m_count  = 0;
      m_wr_err = 1'b0;
      m_rd_err = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.rd_ready = 1'b0;
      bus.flush    = 1'b0;

      do_reset("rst0");

      // Reset mid-stream with data and an error flag already present
      for (int i = 0; i < 3; i++) cyc(1'b1, 12'(12'h0F1 + i), 1'b0, 1'b0, "pre");
      cyc(1'b0, 12'h0, 1'b1, 1'b0, "pre_rd");
      cyc(1'b0, 12'h0, 1'b1, 1'b0, "pre_rd");
      cyc(1'b0, 12'h0, 1'b1, 1'b0, "pre_rd");
      cyc(1'b0, 12'h0, 1'b1, 1'b0, "pre_rderr");
      cyc(1'b1, 12'h0F5, 1'b0, 1'b0, "pre");
      do_reset("rst_mid");

      // Fill to full, then overflow attempt
      for (int i = 1; i <= 8; i++) cyc(1'b1, 12'(i), 1'b0, 1'b0, "fill");
      cyc(1'b1, 12'h009, 1'b0, 1'b0, "fill_ovf");

      // Drain in order, then underflow attempt
      for (int i = 0; i < 8; i++) cyc(1'b0, 12'h0, 1'b1, 1'b0, "drain");
      cyc(1'b0, 12'h0, 1'b1, 1'b0, "drain_unf");

      // Streaming across pointer wrap with constant occupancy
      for (int i = 0; i < 3; i++) cyc(1'b1, 12'(12'h9F0 + i), 1'b0, 1'b0, "prime");
      for (int i = 0; i < 20; i++) cyc(1'b1, 12'(12'hA00 + i), 1'b1, 1'b0, "stream");
      chk("stream_hold", 32'(bus.count), 32'd3);

      // Empty edge: simultaneous write and rd_ready performs no read
      for (int i = 0; i < 3; i++) cyc(1'b0, 12'h0, 1'b1, 1'b0, "empty_drain");
      cyc(1'b1, 12'h555, 1'b1, 1'b0, "empty_edge");
      chk("empty_edge_cnt", 32'(bus.count), 32'd1);

      // Full edge: simultaneous read and write refuses the write
      for (int i = 0; i < 7; i++) cyc(1'b1, 12'(12'h700 + i), 1'b0, 1'b0, "refill");
      cyc(1'b1, 12'h777, 1'b1, 1'b0, "full_edge");
      chk("full_edge_cnt", 32'(bus.count), 32'd7);

      // Flush with 5 entries and a same-cycle write
      cyc(1'b0, 12'h0, 1'b1, 1'b0, "to5");
      cyc(1'b0, 12'h0, 1'b1, 1'b0, "to5");
      chk("flush_pre_cnt", 32'(bus.count), 32'd5);
      cyc(1'b1, 12'h999, 1'b0, 1'b1, "flush");
      chk("flush_rd_valid", 32'(bus.rd_valid), 32'h0);
      cyc(1'b1, 12'h123, 1'b0, 1'b0, "post_flush_wr");
      chk("post_flush_data", 32'(bus.rd_data), 32'h123);
      cyc(1'b0, 12'h0, 1'b1, 1'b0, "post_flush_rd");

      // Sticky errors clear only on reset
      do_reset("rst_end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
